// File: rtl/mem_pkg.sv
// Shared types and defaults for the backing-memory responder.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 256;
   localparam int DEF_LATENCY    = 3;
   localparam int CNT_W          = 4;

endpackage

// File: rtl/component_down_counter.sv
// Loadable down counter that saturates at zero; load wins over decrement.
module component_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/component_register.sv
// Enabled register with asynchronous active-low clear.
module component_register #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, wait LATENCY edges, commit and
// strobe a one-cycle response carrying read data (or zero for a write).
module mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int LATENCY    = DEF_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  busy
);

   localparam int               REQ_W    = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

   state_e                  state_q, state_d;
   logic                    accept;
   logic                    commit;
   logic                    cnt_zero;
   logic [REQ_W-1:0]        lat_q;
   logic                    lat_we;
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   assign accept = (state_q == IDLE) && req_valid;
   assign commit = (state_q == WAIT) && cnt_zero;

   component_register #(
      .WIDTH (REQ_W)
   ) u_req_latch (
      .clk   (clk),
      .rst_n (rst),
      .en_i  (accept),
      .d_i   ({req_we, req_addr, req_wdata}),
      .q_o   (lat_q)
   );

   assign {lat_we, lat_addr, lat_wdata} = lat_q;

   component_down_counter #(
      .WIDTH (CNT_W)
   ) u_lat_cnt (
      .clk        (clk),
      .rst_n      (rst),
      .load_i     (accept),
      .load_val_i (LOAD_VAL),
      .dec_i      (state_q == WAIT),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = WAIT;
         WAIT:    if (cnt_zero)  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Commit happens on the WAIT->RESP edge, so a following read sees the new word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else if (commit) begin
         rdata_q <= lat_we ? '0 : mem_q[lat_addr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '{default: '0};
      end else if (commit && lat_we) begin
         mem_q[lat_addr] <= lat_wdata;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance at LATENCY=3, one at LATENCY=1.
module tb_mem_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_we;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       rv3, rv1;
   logic       rdy3, rdy1, vld3, vld1, busy3, busy1;
   logic [7:0] rd3, rd1;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t q3[$];
   exp_t q1[$];
   exp_t m3, m1;
   bit   prev3 = 1'b0;
   bit   prev1 = 1'b0;
   int   last_acc [2];
   bit   have_last [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.DATA_WIDTH(8), .DEPTH(256), .LATENCY(3)) dut3 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (rv3),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (rdy3),
      .resp_valid (vld3),
      .resp_rdata (rd3),
      .busy       (busy3)
   );

   mem_responder #(.DATA_WIDTH(8), .DEPTH(256), .LATENCY(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (rv1),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (rdy1),
      .resp_valid (vld1),
      .resp_rdata (rd1),
      .busy       (busy1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // sel=0 drives dut3, sel=1 drives dut1. gap>0 checks spacing from the previous acceptance.
   task automatic issue(input bit sel, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] expd,
                        input bit push, input bit keep, input int gap);
      int   t;
      int   acc;
      exp_t e;
      @(negedge clk);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      if (sel) rv1 = 1'b1; else rv3 = 1'b1;
      t = 0;
      while (!(sel ? rdy1 : rdy3) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", t);
         rv1 = 1'b0;
         rv3 = 1'b0;
         return;
      end
      @(negedge clk);
      acc = cyc;
      chk(sel ? "busy1_after_accept" : "busy3_after_accept", sel ? busy1 : busy3, 1);
      if (!keep) begin
         if (sel) rv1 = 1'b0; else rv3 = 1'b0;
      end
      if (gap > 0 && have_last[sel]) chk("accept_spacing", acc - last_acc[sel], gap);
      last_acc[sel]  = acc;
      have_last[sel] = 1'b1;
      if (push) begin
         e.data = expd;
         e.cyc  = acc + (sel ? 1 : 3);
         if (sel) q1.push_back(e); else q3.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (vld3) begin
            chk("resp3_back_to_back", prev3, 0);
            if (q3.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp3_unexpected: resp_valid=1 with rdata %0h, required no response", rd3);
            end else begin
               m3 = q3.pop_front();
               chk("resp3_data", rd3, m3.data);
               chk("resp3_latency", cyc, m3.cyc);
            end
         end
         if (vld1) begin
            chk("resp1_back_to_back", prev1, 0);
            if (q1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp1_unexpected: resp_valid=1 with rdata %0h, required no response", rd1);
            end else begin
               m1 = q1.pop_front();
               chk("resp1_data", rd1, m1.data);
               chk("resp1_latency", cyc, m1.cyc);
            end
         end
      end
      prev3 = vld3;
      prev1 = vld1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc;
      rst       = 1'b0;
      rv3       = 1'b0;
      rv1       = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      have_last = '{default: 1'b0};
      #2;
      chk("rst_ready3", rdy3, 1);
      chk("rst_valid3", vld3, 0);
      chk("rst_busy3",  busy3, 0);
      chk("rst_rdata3", rd3, 0);
      chk("rst_ready1", rdy1, 1);
      chk("rst_valid1", vld1, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // First read after reset: latency and ready timing.
      issue(0, 1'b0, 8'h10, 8'h00, 8'h00, 1, 0, 0);
      acc = last_acc[0];
      repeat (3) @(negedge clk);
      chk("ready3_during_resp", rdy3, 0);
      @(negedge clk);
      chk("ready3_after_resp", rdy3, 1);
      chk("cycles_to_ready", cyc - acc, 4);

      // Write then read-back.
      issue(0, 1'b1, 8'h10, 8'h5A, 8'h00, 1, 0, 0);
      issue(0, 1'b0, 8'h10, 8'h00, 8'h5A, 1, 0, 0);

      // Continuous req_valid, alternating addresses.
      issue(0, 1'b1, 8'h01, 8'hA1, 8'h00, 1, 0, 0);
      issue(0, 1'b1, 8'h02, 8'hB2, 8'h00, 1, 0, 0);
      issue(0, 1'b0, 8'h01, 8'h00, 8'hA1, 1, 1, 0);
      issue(0, 1'b0, 8'h02, 8'h00, 8'hB2, 1, 1, 5);
      issue(0, 1'b0, 8'h01, 8'h00, 8'hA1, 1, 1, 5);
      issue(0, 1'b0, 8'h02, 8'h00, 8'hB2, 1, 0, 5);

      // Request fields change while the write is waiting.
      issue(0, 1'b1, 8'h20, 8'h11, 8'h00, 1, 0, 0);
      @(negedge clk);
      req_addr  = 8'h21;
      req_wdata = 8'hEE;
      issue(0, 1'b0, 8'h21, 8'h00, 8'h00, 1, 0, 0);
      issue(0, 1'b0, 8'h20, 8'h00, 8'h11, 1, 0, 0);

      // Reset in the middle of a write.
      issue(0, 1'b1, 8'h30, 8'hFF, 8'h00, 0, 0, 0);
      @(negedge clk);
      chk("pre_rst_rdata3", rd3, 8'h11);
      rst = 1'b0;
      #1;
      chk("midrst_ready3", rdy3, 1);
      chk("midrst_valid3", vld3, 0);
      chk("midrst_busy3",  busy3, 0);
      chk("midrst_rdata3", rd3, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      have_last = '{default: 1'b0};
      issue(0, 1'b0, 8'h30, 8'h00, 8'h00, 1, 0, 0);
      issue(0, 1'b0, 8'h10, 8'h00, 8'h00, 1, 0, 0);

      // LATENCY=1 instance: top and bottom of the array, back-to-back reads.
      issue(1, 1'b1, 8'hFF, 8'hC3, 8'h00, 1, 0, 0);
      issue(1, 1'b1, 8'h00, 8'h3C, 8'h00, 1, 0, 0);
      issue(1, 1'b0, 8'h00, 8'h00, 8'h3C, 1, 1, 0);
      issue(1, 1'b0, 8'hFF, 8'h00, 8'hC3, 1, 0, 3);

      repeat (10) @(negedge clk);
      chk("q3_drained", q3.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Backing-memory responder that services the cache controller's miss-fill and write traffic. It is the memory side of the cache write-enable sequencing. It accepts one request at a time over a valid/ready handshake, waits a programmable access latency, then returns read data or a write acknowledge as a one-cycle response strobe. It holds the word-addressed storage array that the cache fills from and writes through to.

## Interface
- DATA_WIDTH, 8: width of one memory word
- DEPTH, 256: number of words; power of two, ≥2
- ADDR_WIDTH, $clog2(DEPTH): word address width
- LATENCY, 3: clock edges from request acceptance to response; legal range 1–15
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  initiator presents a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data, ignored for reads
- req_ready  output  1  responder can accept a request this cycle
- resp_valid  output  1  one-cycle response strobe
- resp_rdata  output  DATA_WIDTH  read data; valid only while resp_valid=1 on a read
- busy  output  1  request in flight (state ≠ IDLE)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On an edge where req_valid&req_ready=1:
  - latch req_we, req_addr and req_wdata
  - load the latency counter with LATENCY−1
  - go to WAIT
- WAIT: req_ready=0.
  - If counter ≠ 0, decrement it.
  - If counter = 0, go to RESP. On this same edge:
    - read: resp_rdata ← mem[addr]
    - write: mem[addr] ← wdata, and resp_rdata ← 0
- RESP: resp_valid=1 for exactly this one cycle. Go to IDLE on the next edge unconditionally.
- The initiator holds req_* stable until acceptance. req_* is sampled only on the accepting edge; later changes have no effect on the request in flight.
- req_valid outside IDLE is ignored. There is no queueing.
- Read-after-write to the same address returns the new data, because the write commits before resp_valid.
- Counter width is 4 bits. The counter never wraps because it is loaded only in IDLE and stops at 0.
- Reset (rst=0), at any time including mid-request:
  - state → IDLE
  - counter → 0
  - latched request is discarded; a pending write is never committed
  - all memory words → 0
  - outputs: req_ready=1, resp_valid=0, resp_rdata=0, busy=0
  - Outputs update asynchronously on the falling edge of rst.

## Timing
- Request accepted at edge E0, resp_valid is high in the cycle after edge E0+LATENCY, and req_ready is high again after edge E0+LATENCY+1.
- Maximum throughput is one request per LATENCY+2 cycles. With LATENCY=3, that is one request every 5 cycles.
- With LATENCY=1: E0 enters WAIT, E1 enters RESP, E2 returns to IDLE.
- resp_valid is never high for two consecutive cycles.
- resp_rdata holds its value after RESP until the next response or reset. The initiator must ignore it when resp_valid=0.

## Structure
- Package mem_pkg holds:
  - the state enum type (IDLE, WAIT, RESP)
  - the default DATA_WIDTH, DEPTH and LATENCY constants
  - the counter width constant, 4
- The request latch uses the existing component_register, WIDTH=1+ADDR_WIDTH+DATA_WIDTH, with en=accept.
- One new sub-module, component_down_counter:
  - parameterized width
  - ports: load, load value, decrement enable, zero flag
  - async active-low reset to 0

## Test plan
- Reset, then read addr 0x10 with LATENCY=3, accept at E0 → resp_valid=1 only after E3, resp_rdata=0x00, req_ready=1 after E4.
- Write 0x5A to 0x10, then read 0x10 → write response strobes once after E0+3; read returns 0x5A.
- Hold req_valid high continuously with alternating addresses 0x01 and 0x02 → requests accepted only in IDLE, exactly every 5 cycles; no response is dropped or duplicated.
- Change req_addr and req_wdata during WAIT of a write to 0x20 with data 0x11 → mem[0x20]=0x11; the changed values have no effect.
- Assert rst during WAIT of a write 0xFF to 0x30 → no resp_valid; outputs at reset values immediately; a later read of 0x30 returns 0x00.
- LATENCY=1, back-to-back reads of 0x00 and DEPTH−1 → each resp_valid comes one edge after acceptance; the address wraps to the top of the array correctly.
